// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb
//
// Write-port arbiter and pending-write scoreboard for the general-purpose
// register file. Two write-back sources compete for the single write port.
// The winning write is registered and presented to the register file one
// cycle later. A per-register pending bitmap tracks claimed writes that have
// not yet been accepted, so issue logic can detect read-after-write hazards.
//
// Configuration macro:
//   WPORT_RR_EN  defined   -> round-robin between the two sources
//                undefined -> fixed priority, source 0 always wins contention
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/addr/data/ready    pipeline write-back source (ready is comb)
//   req1_valid/addr/data/ready    long-latency source (ready is comb)
//   claim_valid, claim_addr       issue-time claim of a destination register
//   we, waddr, wdata              registered register-file write port
//   pend                          pending-write bitmap, bit 0 always 0

module regfile_wport_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    input  logic [ADDR_W-1:0]        req0_addr,
    input  logic [DATA_W-1:0]        req0_data,
    output logic                     req0_ready,

    input  logic                     req1_valid,
    input  logic [ADDR_W-1:0]        req1_addr,
    input  logic [DATA_W-1:0]        req1_data,
    output logic                     req1_ready,

    input  logic                     claim_valid,
    input  logic [ADDR_W-1:0]        claim_addr,

    output logic                     we,
    output logic [ADDR_W-1:0]        waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic [(1<<ADDR_W)-1:0]   pend
);

    localparam int NREG = 1 << ADDR_W;

    logic                grant0;
    logic                grant1;
    logic                acc;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;

    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NREG-1:0]     pend_q;
    logic [NREG-1:0]     pend_d;

`ifdef WPORT_RR_EN
    // last_q = 1 means source 1 was granted most recently, so source 0 wins
    // the next contention. Reset to 1 so source 0 wins the first one.
    logic last_q;

    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (acc) begin
            last_q <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = req0_valid;
    end
`endif

    assign grant1   = req1_valid & ~grant0;
    assign acc      = grant0 | grant1;
    assign acc_addr = grant0 ? req0_addr : req1_addr;
    assign acc_data = grant0 ? req0_data : req1_data;

    // Clear first, then set: a same-cycle claim belongs to a newer producer
    // and must keep the bit high.
    always_comb begin
        pend_d = pend_q;
        if (acc) begin
            pend_d[acc_addr] = 1'b0;
        end
        if (claim_valid && (claim_addr != '0)) begin
            pend_d[claim_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            // Register 0 writes are consumed but never reach the file.
            we_q   <= acc && (acc_addr != '0);
            if (acc) begin
                waddr_q <= acc_addr;
                wdata_q <= acc_data;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_regfile_wport_arb.sv
module tb_regfile_wport_arb;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid, claim_valid;
    logic [4:0]  req0_addr, req1_addr, claim_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pend;

    regfile_wport_arb #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .pend        (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: what the register file should see, the pending set,
    // and which source was granted last.
    bit [31:0] m_pend;
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;
    int        m_last;
    int        exp_grant;
    int        obs_grant;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_last  = 1;
    endtask

    function automatic int model_grant(input bit v0, input bit v1);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
        if (!v0 && !v1) return -1;
`ifdef WPORT_RR_EN
        return (m_last == 1) ? 0 : 1;
`else
        return 0;
`endif
    endfunction

    // Entered at a falling edge; drives one cycle of inputs, checks the
    // combinational grant, advances the model across the rising edge and
    // checks the registered outputs at the following falling edge.
    task automatic drive_cycle(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                               input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                               input bit cv, input bit [4:0] ca);
        bit [4:0]  ga;
        bit [31:0] gd;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        claim_valid = cv; claim_addr = ca;
        #1;
        exp_grant = model_grant(v0, v1);
        obs_grant = req0_ready ? 0 : (req1_ready ? 1 : -1);
        chk("req0_ready", req0_ready, exp_grant == 0);
        chk("req1_ready", req1_ready, exp_grant == 1);
        if (exp_grant >= 0) begin
            ga = (exp_grant == 0) ? a0 : a1;
            gd = (exp_grant == 0) ? d0 : d1;
            m_we     = (ga != 0);
            m_waddr  = ga;
            m_wdata  = gd;
            m_pend[ga] = 1'b0;
            m_last   = exp_grant;
        end else begin
            m_we = 1'b0;
        end
        if (cv && ca != 0) m_pend[ca] = 1'b1;
        @(negedge clk);
        chk("we", we, m_we);
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("pend", pend, m_pend);
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int        exp_seq[4];
    bit [31:0] d0c, d1c, pend_snap;
    bit        p0_v, p1_v;
    bit [4:0]  p0_a, p1_a;
    bit [31:0] p0_d, p1_d;

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        claim_valid = 0; claim_addr = 0;
        model_reset();
        #1;
        chk("rst_we", we, 0);
        chk("rst_pend", pend, 0);
        @(negedge clk);
        rst = 1'b0;

        // Contention from a fresh reset.
`ifdef WPORT_RR_EN
        exp_seq = '{0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0};
`endif
        d0c = 32'h11; d1c = 32'h22;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, 3, d0c, 1, 4, d1c, 0, 0);
            chk("cont_grant", obs_grant, exp_seq[i]);
            if (exp_seq[i] == 0) d0c = d0c + 1; else d1c = d1c + 1;
        end
        idle_cycle();

        // Single source.
        drive_cycle(0, 0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
        chk("single_ready1", obs_grant, 1);
        chk("single_we", we, 1);
        chk("single_waddr", waddr, 7);
        chk("single_wdata", wdata, 32'hDEADBEEF);
        idle_cycle();
        chk("single_we_drop", we, 0);
        chk("single_waddr_hold", waddr, 7);

        // Register 0.
        pend_snap = pend;
        drive_cycle(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
        chk("r0_ready", obs_grant, 0);
        chk("r0_we", we, 0);
        chk("r0_pend", pend, pend_snap);

        // Scoreboard.
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 9);
        chk("sb_claim", pend[9], 1);
        idle_cycle();
        drive_cycle(0, 0, 0, 1, 9, 32'h99, 1, 9);
        chk("sb_collide_pend", pend[9], 1);
        chk("sb_collide_we", we, 1);
        drive_cycle(0, 0, 0, 1, 9, 32'h9A, 0, 0);
        chk("sb_clear_pend", pend[9], 0);
        chk("sb_clear_we", we, 1);
        chk("sb_clear_wdata", wdata, 32'h9A);

        // Claim of r0.
        pend_snap = pend;
        drive_cycle(0, 0, 0, 0, 0, 0, 1, 0);
        chk("claim_r0", pend, pend_snap);

        // Reset mid-stream.
        drive_cycle(0, 0, 0, 1, 6, 32'h66, 1, 5);
        chk("pre_rst_pend5", pend[5], 1);
        req0_valid = 1; req0_addr = 5; req0_data = 32'h55;
        claim_valid = 1; claim_addr = 5;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_we", we, 0);
        chk("async_rst_waddr", waddr, 0);
        chk("async_rst_wdata", wdata, 0);
        chk("async_rst_pend", pend, 0);
        req0_valid = 0; claim_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_cycle(0, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("post_rst_ready_lo", obs_grant, -1);
        drive_cycle(1, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("post_rst_ready_hi", obs_grant, 0);

        // Randomized traffic; a source holds its request until granted.
        p0_v = 0; p1_v = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0_v && ($urandom_range(0, 2) != 0)) begin
                p0_v = 1; p0_a = 5'($urandom_range(0, 7)); p0_d = $urandom;
            end
            if (!p1_v && ($urandom_range(0, 2) != 0)) begin
                p1_v = 1; p1_a = 5'($urandom_range(0, 7)); p1_d = $urandom;
            end
            drive_cycle(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
            if (exp_grant == 0) p0_v = 0;
            if (exp_grant == 1) p1_v = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
